// File: rtl/coin_accept_fsm.sv
// Coin acceptor: front half of the vending dispense pipeline.
// Accumulates coin credit in nickel units, issues a one-hot exact/change code
// when the price is reached, keeps the nickel/dime inventory and applies the
// payout reported back by the dispense stage.
module coin_accept_fsm #(
    parameter int unsigned PRICE       = 12,     // item price in nickel units
    parameter logic [7:0]  NICKEL_INIT = 8'd10,  // nickel inventory after reset
    parameter logic [7:0]  DIME_INIT   = 8'd10   // dime inventory after reset
) (
    input  logic       clock,
    input  logic       reset,          // asynchronous, active-low
    input  logic [1:0] coin,           // 00 none, 01 nickel, 10 dime, 11 quarter
    input  logic [7:0] subNickel,      // nickels paid out (valid in WAIT)
    input  logic [7:0] subDime,        // dimes paid out (valid in WAIT)
    output logic [5:0] dispenseReady,  // 100000 idle, else one-hot change code
    output logic [4:0] credit,
    output logic [7:0] nickelCount,
    output logic [7:0] dimeCount,
    output logic       busy,
    output logic       coinReject,
    output logic       changeShort
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [4:0] PRICE_N    = 5'(PRICE);
    localparam logic [5:0] READY_IDLE = 6'b100000;

    state_t     r_state,  w_state_nxt;
    logic [4:0] r_credit, w_credit_nxt;
    logic [5:0] r_ready,  w_ready_nxt;
    logic [7:0] r_nickel, w_nickel_nxt;
    logic [7:0] r_dime,   w_dime_nxt;
    logic       r_busy,   w_busy_nxt;
    logic       r_reject, w_reject_nxt;
    logic       r_short,  w_short_nxt;

    logic [4:0]  w_coin_val;
    logic [4:0]  w_sum;
    logic [4:0]  w_accum_excess;
    logic [5:0]  w_code;
    logic [4:0]  w_wait_excess;
    logic        w_exact;
    logic [11:0] w_owed;
    logic [11:0] w_paid;

    // Coin value in nickel units and the resulting change code.
    always_comb begin
        unique case (coin)
            2'b01:   w_coin_val = 5'd1;
            2'b10:   w_coin_val = 5'd2;
            2'b11:   w_coin_val = 5'd5;
            default: w_coin_val = 5'd0;
        endcase
        // Credit is at most PRICE-1 in ACCUM, so the sum never exceeds PRICE+4.
        w_sum          = r_credit + w_coin_val;
        w_accum_excess = w_sum - PRICE_N;
        unique case (w_accum_excess)
            5'd0:    w_code = 6'b000001;
            5'd1:    w_code = 6'b000010;
            5'd2:    w_code = 6'b000100;
            5'd3:    w_code = 6'b001000;
            5'd4:    w_code = 6'b010000;
            default: w_code = READY_IDLE;
        endcase
    end

    // Change owed vs. change reported paid, both in cents. 12 bits holds the
    // worst case 255*5 + 255*10 = 3825 without wrapping.
    assign w_wait_excess = r_credit - PRICE_N;
    assign w_exact       = (w_wait_excess == 5'd0);
    assign w_owed        = {7'd0, w_wait_excess} * 12'd5;
    assign w_paid        = ({4'd0, subNickel} * 12'd5) + ({4'd0, subDime} * 12'd10);

    // Next-state and next-output logic for the sale sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_ready_nxt  = r_ready;
        w_nickel_nxt = r_nickel;
        w_dime_nxt   = r_dime;
        w_busy_nxt   = r_busy;
        w_reject_nxt = 1'b0;
        w_short_nxt  = r_short;

        unique case (r_state)
            ST_ACCUM: begin
                if (coin != 2'b00) begin
                    w_credit_nxt = w_sum;
                    if (coin == 2'b01 && r_nickel != 8'hFF) w_nickel_nxt = r_nickel + 8'd1;
                    if (coin == 2'b10 && r_dime != 8'hFF)   w_dime_nxt   = r_dime + 8'd1;
                    if (w_sum >= PRICE_N) begin
                        w_state_nxt = ST_ISSUE;
                        w_ready_nxt = w_code;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                w_reject_nxt = (coin != 2'b00);
                w_ready_nxt  = READY_IDLE;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                w_reject_nxt = (coin != 2'b00);
                if (w_exact) begin
                    // Exact sale: the payout inputs are meaningless and ignored.
                    w_short_nxt = 1'b0;
                end else begin
                    w_nickel_nxt = (subNickel > r_nickel) ? 8'd0 : r_nickel - subNickel;
                    w_dime_nxt   = (subDime > r_dime)     ? 8'd0 : r_dime - subDime;
                    w_short_nxt  = (w_paid != w_owed);
                end
                w_credit_nxt = 5'd0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = ST_ACCUM;
            end
            default: begin
                w_state_nxt  = ST_ACCUM;
                w_credit_nxt = 5'd0;
                w_ready_nxt  = READY_IDLE;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any sale in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_ACCUM;
            r_credit <= 5'd0;
            r_ready  <= READY_IDLE;
            r_nickel <= NICKEL_INIT;
            r_dime   <= DIME_INIT;
            r_busy   <= 1'b0;
            r_reject <= 1'b0;
            r_short  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_ready  <= w_ready_nxt;
            r_nickel <= w_nickel_nxt;
            r_dime   <= w_dime_nxt;
            r_busy   <= w_busy_nxt;
            r_reject <= w_reject_nxt;
            r_short  <= w_short_nxt;
        end
    end

    assign dispenseReady = r_ready;
    assign credit        = r_credit;
    assign nickelCount   = r_nickel;
    assign dimeCount     = r_dime;
    assign busy          = r_busy;
    assign coinReject    = r_reject;
    assign changeShort   = r_short;

endmodule

// File: tb/tb_coin_accept_fsm.sv
// Bench for coin_accept_fsm: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural sale model.
module tb_coin_accept_fsm;

    localparam int         PRICE = 12;
    localparam logic [5:0] IDLE  = 6'b100000;
    localparam logic [1:0] C_0 = 2'd0, C_N = 2'd1, C_D = 2'd2, C_Q = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'd0;
    logic [7:0] subNickel = 8'd0;
    logic [7:0] subDime = 8'd0;
    logic [5:0] dispenseReady;
    logic [4:0] credit;
    logic [7:0] nickelCount;
    logic [7:0] dimeCount;
    logic       busy;
    logic       coinReject;
    logic       changeShort;

    int n_cmp = 0;
    int n_bad = 0;

    coin_accept_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .coin          (coin),
        .subNickel     (subNickel),
        .subDime       (subDime),
        .dispenseReady (dispenseReady),
        .credit        (credit),
        .nickelCount   (nickelCount),
        .dimeCount     (dimeCount),
        .busy          (busy),
        .coinReject    (coinReject),
        .changeShort   (changeShort)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // A sale is "cycles left busy": 2 while the code is shown, 1 while the
    // payout is reported, 0 while coins are taken.
    int m_credit, m_nick, m_dime, m_busy_left;
    bit m_rej, m_short;

    task automatic model_reset();
        m_credit = 0; m_nick = 10; m_dime = 10; m_busy_left = 0;
        m_rej = 0; m_short = 0;
    endtask

    task automatic model_edge(input logic [1:0] c, input int sn, input int sd);
        int val;
        case (c)
            C_N:     val = 1;
            C_D:     val = 2;
            C_Q:     val = 5;
            default: val = 0;
        endcase
        m_rej = 0;
        if (m_busy_left == 2) begin
            m_rej = (c != 0);
            m_busy_left = 1;
        end else if (m_busy_left == 1) begin
            m_rej = (c != 0);
            if (m_credit != PRICE) begin
                m_nick  = (sn > m_nick) ? 0 : m_nick - sn;
                m_dime  = (sd > m_dime) ? 0 : m_dime - sd;
                m_short = (sn * 5 + sd * 10) != (m_credit - PRICE) * 5;
            end else begin
                m_short = 0;
            end
            m_credit = 0;
            m_busy_left = 0;
        end else if (val != 0) begin
            m_credit += val;
            if (c == C_N && m_nick < 255) m_nick++;
            if (c == C_D && m_dime < 255) m_dime++;
            if (m_credit >= PRICE) m_busy_left = 2;
        end
    endtask

    function automatic logic [31:0] pack(logic [5:0] r, logic [4:0] cr, logic [7:0] n,
                                         logic [7:0] d, logic b, logic rj, logic sh);
        return {2'b00, r, cr, n, d, b, rj, sh};
    endfunction

    function automatic logic [31:0] model_pack();
        logic [5:0] r;
        r = (m_busy_left == 2) ? 6'(1 << (m_credit - PRICE)) : IDLE;
        return pack(r, 5'(m_credit), 8'(m_nick), 8'(m_dime), m_busy_left != 0, m_rej, m_short);
    endfunction

    function automatic logic [31:0] dut_pack();
        return pack(dispenseReady, credit, nickelCount, dimeCount, busy, coinReject, changeShort);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, compare every output to the model.
    task automatic cycle(input logic [1:0] c, input logic [7:0] sn, input logic [7:0] sd,
                         input string name);
        coin = c; subNickel = sn; subDime = sd;
        @(posedge clock); #1;
        model_edge(c, int'(sn), int'(sd));
        check(name, dut_pack(), model_pack());
    endtask

    task automatic do_reset();
        coin = 0; subNickel = 0; subDime = 0;
        @(negedge clock); reset = 1'b0; #1;
        model_reset();
        check("reset_vals", dut_pack(), pack(IDLE, 5'd0, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0));
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] coin;
        logic [7:0] sn;
        logic [7:0] sd;
        logic [5:0] ready;
        logic [4:0] credit;
        logic [7:0] nick;
        logic [7:0] dime;
        logic       busy;
        logic       rej;
        logic       shrt;
    } vec_t;

    vec_t vecs[23];

    initial begin
        int n, d, ch;
        // exact sale Q,Q,D
        vecs[0]  = '{C_Q, 8'd0, 8'd0, IDLE,      5'd5,  8'd10, 8'd10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{C_Q, 8'd0, 8'd0, IDLE,      5'd10, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{C_D, 8'd0, 8'd0, 6'b000001, 5'd12, 8'd10, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{C_0, 8'd0, 8'd0, IDLE,      5'd12, 8'd10, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{C_0, 8'd0, 8'd0, IDLE,      5'd0,  8'd10, 8'd11, 1'b0, 1'b0, 1'b0};
        // 20c change paid with two dimes
        vecs[5]  = '{C_Q, 8'd0, 8'd0, IDLE,      5'd5,  8'd10, 8'd11, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{C_Q, 8'd0, 8'd0, IDLE,      5'd10, 8'd10, 8'd11, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{C_N, 8'd0, 8'd0, IDLE,      5'd11, 8'd11, 8'd11, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{C_Q, 8'd0, 8'd0, 6'b010000, 5'd16, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{C_0, 8'd0, 8'd0, IDLE,      5'd16, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{C_0, 8'd0, 8'd2, IDLE,      5'd0,  8'd11, 8'd9,  1'b0, 1'b0, 1'b0};
        // 10c change, nothing paid -> shortfall
        vecs[11] = '{C_Q, 8'd0, 8'd0, IDLE,      5'd5,  8'd11, 8'd9,  1'b0, 1'b0, 1'b0};
        vecs[12] = '{C_D, 8'd0, 8'd0, IDLE,      5'd7,  8'd11, 8'd10, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{C_D, 8'd0, 8'd0, IDLE,      5'd9,  8'd11, 8'd11, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{C_Q, 8'd0, 8'd0, 6'b000100, 5'd14, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{C_0, 8'd0, 8'd0, IDLE,      5'd14, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{C_0, 8'd0, 8'd0, IDLE,      5'd0,  8'd11, 8'd11, 1'b0, 1'b0, 1'b1};
        // exact sale with dime held through the busy cycles; clears shortfall
        vecs[17] = '{C_Q, 8'd0, 8'd0, IDLE,      5'd5,  8'd11, 8'd11, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{C_Q, 8'd0, 8'd0, IDLE,      5'd10, 8'd11, 8'd11, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{C_D, 8'd0, 8'd0, 6'b000001, 5'd12, 8'd11, 8'd12, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{C_D, 8'd0, 8'd0, IDLE,      5'd12, 8'd11, 8'd12, 1'b1, 1'b1, 1'b1};
        vecs[21] = '{C_D, 8'd7, 8'd7, IDLE,      5'd0,  8'd11, 8'd12, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{C_0, 8'd0, 8'd0, IDLE,      5'd0,  8'd11, 8'd12, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 23; i++) begin
            coin = vecs[i].coin; subNickel = vecs[i].sn; subDime = vecs[i].sd;
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(vecs[i].ready, vecs[i].credit, vecs[i].nick, vecs[i].dime,
                       vecs[i].busy, vecs[i].rej, vecs[i].shrt));
        end

        // ---- exact sale with empty dime stock ----
        do_reset();
        cycle(C_Q, 0, 0, "drain_q1"); cycle(C_Q, 0, 0, "drain_q2"); cycle(C_Q, 0, 0, "drain_q3");
        cycle(C_0, 0, 0, "drain_issue");
        cycle(C_0, 0, 10, "drain_wait");
        check("drain_dime", 32'(dimeCount), 32'd0);
        cycle(C_Q, 0, 0, "t3_q1"); cycle(C_Q, 0, 0, "t3_q2"); cycle(C_D, 0, 0, "t3_d");
        check("t3_code", 32'(dispenseReady), 32'(6'b000001));
        check("t3_dime", 32'(dimeCount), 32'd1);
        check("t3_nick", 32'(nickelCount), 32'd10);
        cycle(C_0, 0, 0, "t3_issue"); cycle(C_0, 0, 0, "t3_wait");
        check("t3_short", 32'(changeShort), 32'd0);

        // ---- nickel payout floored at zero ----
        cycle(C_Q, 0, 0, "fl_q1"); cycle(C_Q, 0, 0, "fl_q2"); cycle(C_Q, 0, 0, "fl_q3");
        cycle(C_0, 0, 0, "fl_issue"); cycle(C_0, 5, 0, "fl_wait");
        check("nick_after5", 32'(nickelCount), 32'd5);
        cycle(C_Q, 0, 0, "fl_q4"); cycle(C_Q, 0, 0, "fl_q5"); cycle(C_Q, 0, 0, "fl_q6");
        cycle(C_0, 0, 0, "fl_issue2"); cycle(C_0, 20, 0, "fl_wait2");
        check("nick_floor", 32'(nickelCount), 32'd0);

        // ---- nickel inventory saturates at 255 ----
        for (int i = 0; i < 2000 && !(m_nick == 255 && m_busy_left == 0); i++)
            cycle((m_busy_left != 0) ? C_0 : C_N, 0, 0, "sat_fill");
        check("nick_full", 32'(nickelCount), 32'd255);
        cycle(C_N, 0, 0, "sat_extra");
        check("nick_sat", 32'(nickelCount), 32'd255);

        // ---- reset in WAIT with credit 16 ----
        do_reset();
        cycle(C_Q, 0, 0, "r6_q1"); cycle(C_Q, 0, 0, "r6_q2");
        cycle(C_N, 0, 0, "r6_n");  cycle(C_Q, 0, 0, "r6_q3");
        cycle(C_0, 0, 0, "r6_issue");
        check("r6_credit16", 32'(credit), 32'd16);
        subNickel = 8'd3;
        #2 reset = 1'b0;
        #1 check("rst_in_wait", dut_pack(), pack(IDLE, 5'd0, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0));
        @(posedge clock); #1;
        check("rst_no_sub", dut_pack(), pack(IDLE, 5'd0, 8'd10, 8'd10, 1'b0, 1'b0, 1'b0));
        @(negedge clock); reset = 1'b1; subNickel = 8'd0;
        model_reset();
        @(posedge clock); #1;

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            int r;
            r = $urandom_range(0, 9);
            c = (r < 4) ? C_0 : (r < 6) ? C_N : (r < 8) ? C_D : C_Q;
            if (m_busy_left == 1 && m_credit != PRICE && $urandom_range(0, 1) == 1) begin
                ch = m_credit - PRICE;
                d  = $urandom_range(0, ch / 2);
                n  = ch - 2 * d;
            end else if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, 255);
                d = $urandom_range(0, 255);
            end else begin
                n = $urandom_range(0, 3);
                d = $urandom_range(0, 2);
            end
            cycle(c, 8'(n), 8'(d), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
